// File: rtl/lse_pkg.sv
// Shared constants, mode encoding and lane helper for the log-sum-exp adder.
package lse_pkg;

    // Fractional bits of the 24-bit format; equal to the correction entry width.
    localparam int unsigned LUT_PRECISION_DEF = 10;
    localparam int unsigned FRAC_BITS         = LUT_PRECISION_DEF;

    localparam logic [23:0] NEG_INF24 = 24'h800000;
    localparam logic [23:0] MAX24     = 24'h7FFFFF;
    localparam logic [5:0]  NEG_INF6  = 6'h20;
    localparam logic [5:0]  MAX6      = 6'h1F;

    typedef enum logic [1:0] {
        MODE_24  = 2'b00,
        MODE_6x4 = 2'b01
    } pe_mode_t;

    // Add the 0/1 lane correction to a lane maximum, clamping at the lane maximum value.
    function automatic logic [5:0] lane_sat_inc(input logic [5:0] mx, input logic inc);
        logic signed [6:0] sum;
        sum = {mx[5], mx} + {6'b0, inc};
        if (sum > 7'sd31) begin
            return MAX6;
        end
        return sum[5:0];
    endfunction

endpackage

// File: rtl/lse_lane6.sv
// Combinational front half of one 6-bit packed lane: resolves NEG_INF bypass,
// picks the signed maximum and decides whether the +1 correction applies.
module lse_lane6
    import lse_pkg::*;
(
    input  logic [5:0] a,
    input  logic [5:0] b,
    output logic [5:0] mx,
    output logic       inc
);

    logic signed [6:0] a_ext;
    logic signed [6:0] b_ext;
    logic signed [6:0] diff;
    logic              a_gt;

    // Bypass on NEG_INF, otherwise max plus "operands within one" flag.
    always_comb begin
        a_ext = {a[5], a};
        b_ext = {b[5], b};
        a_gt  = (a_ext > b_ext);
        diff  = a_gt ? (a_ext - b_ext) : (b_ext - a_ext);
        mx    = b;
        inc   = 1'b0;
        if (a == NEG_INF6) begin
            mx  = b;
            inc = 1'b0;
        end else if (b == NEG_INF6) begin
            mx  = a;
            inc = 1'b0;
        end else begin
            mx  = a_gt ? a : b;
            inc = (diff <= 7'sd1);
        end
    end

endmodule

// File: rtl/lse_add.sv
// Two-stage pipelined log-sum-exp adder: log2(2^a + 2^b) as max plus a correction.
// Stage 1 resolves bypass, max and difference; stage 2 reads the table, adds and saturates.
module lse_add
    import lse_pkg::*;
#(
    parameter int unsigned WIDTH         = 24,
    parameter int unsigned LUT_SIZE      = 1024,
    parameter int unsigned LUT_PRECISION = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         operand_a,
    input  logic [WIDTH-1:0]         operand_b,
    input  logic [LUT_PRECISION-1:0] lut_table [0:LUT_SIZE-1],
    input  logic [1:0]               pe_mode,
    output logic [WIDTH-1:0]         result,
    output logic                     valid_out
);

    localparam int unsigned IDX_W = $clog2(LUT_SIZE);

    // Stage-1 combinational signals
    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;
    logic signed [WIDTH:0] diff;
    logic                  a_gt;
    logic [WIDTH-1:0]      mx24;
    logic                  corr_en24;
    logic [IDX_W-1:0]      idx24;
    logic [WIDTH-1:0]      lane_mx;
    logic [3:0]            lane_inc;
    pe_mode_t              mode_d;
    logic [WIDTH-1:0]      s1_mx_d;

    // Stage-1 registers
    logic                  s1_valid;
    pe_mode_t              s1_mode;
    logic [WIDTH-1:0]      s1_mx;
    logic [3:0]            s1_inc;
    logic                  s1_corr_en;
    logic [IDX_W-1:0]      s1_idx;

    // Stage-2 combinational signals
    logic [LUT_PRECISION-1:0] corr;
    logic [WIDTH:0]           sum24;
    logic [WIDTH-1:0]         res24;
    logic [WIDTH-1:0]         res6;
    logic [WIDTH-1:0]         result_d;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        lse_lane6 u_lane (
            .a   (operand_a[6*i +: 6]),
            .b   (operand_b[6*i +: 6]),
            .mx  (lane_mx[6*i +: 6]),
            .inc (lane_inc[i])
        );
    end

    // 24-bit front end: NEG_INF bypass, signed max, difference and table index.
    always_comb begin
        a_ext     = {operand_a[WIDTH-1], operand_a};
        b_ext     = {operand_b[WIDTH-1], operand_b};
        a_gt      = (a_ext > b_ext);
        diff      = a_gt ? (a_ext - b_ext) : (b_ext - a_ext);
        idx24     = diff[IDX_W-1:0];
        mx24      = operand_b;
        corr_en24 = 1'b0;
        if (operand_a == NEG_INF24) begin
            mx24 = operand_b;
        end else if (operand_b == NEG_INF24) begin
            mx24 = operand_a;
        end else begin
            mx24      = a_gt ? operand_a : operand_b;
            // diff is never negative, so an unsigned compare is safe.
            corr_en24 = ($unsigned(diff) < (WIDTH + 1)'(LUT_SIZE));
        end
    end

    // Reserved modes fold onto the scalar path; the max register is shared by both modes.
    always_comb begin
        mode_d  = (pe_mode == MODE_6x4) ? MODE_6x4 : MODE_24;
        s1_mx_d = (mode_d == MODE_6x4) ? lane_mx : mx24;
    end

    // Stage 1: capture on enable; valid tracks enable, data holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_mode    <= MODE_24;
            s1_mx      <= '0;
            s1_inc     <= '0;
            s1_corr_en <= 1'b0;
            s1_idx     <= '0;
        end else begin
            s1_valid <= enable;
            if (enable) begin
                s1_mode    <= mode_d;
                s1_mx      <= s1_mx_d;
                s1_inc     <= lane_inc;
                s1_corr_en <= corr_en24;
                s1_idx     <= idx24;
            end
        end
    end

    // Stage 2 datapath: table correction with positive saturation, or four lane increments.
    always_comb begin
        corr  = s1_corr_en ? lut_table[s1_idx] : '0;
        sum24 = {s1_mx[WIDTH-1], s1_mx} + {{(WIDTH + 1 - LUT_PRECISION){1'b0}}, corr};
        // Only positive overflow is possible: the correction is non-negative.
        res24 = (!sum24[WIDTH] && sum24[WIDTH-1]) ? MAX24 : sum24[WIDTH-1:0];
        res6  = '0;
        for (int k = 0; k < 4; k++) begin
            res6[6*k +: 6] = lane_sat_inc(s1_mx[6*k +: 6], s1_inc[k]);
        end
        result_d = (s1_mode == MODE_6x4) ? res6 : res24;
    end

    // Stage 2: register result when an operation completes, otherwise hold it.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= s1_valid;
            if (s1_valid) begin
                result <= result_d;
            end
        end
    end

endmodule

// File: tb/tb_lse_add.sv
// Self-checking bench for lse_add: directed vectors plus randomized traffic
// against an arithmetic reference model and a two-cycle latency model.
module tb_lse_add;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] operand_a;
    logic [23:0] operand_b;
    logic [1:0]  pe_mode;
    logic [23:0] result;
    logic        valid_out;
    logic [9:0]  lut [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    // Latency model: op captured at the previous edge, and expected outputs.
    logic        p_v = 1'b0;
    logic [23:0] p_r = '0;
    logic        exp_valid = 1'b0;
    logic [23:0] exp_result = '0;

    lse_add #(
        .WIDTH         (24),
        .LUT_SIZE      (1024),
        .LUT_PRECISION (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .lut_table (lut),
        .pe_mode   (pe_mode),
        .result    (result),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ref24(input logic [23:0] a, input logic [23:0] b);
        int ia, ib, mx, mn, d, s;
        logic [23:0] r;
        if (a == 24'h800000) return b;
        if (b == 24'h800000) return a;
        ia = $signed(a);
        ib = $signed(b);
        mx = (ia > ib) ? ia : ib;
        mn = (ia > ib) ? ib : ia;
        d  = mx - mn;
        s  = mx + ((d < 1024) ? int'(lut[d]) : 0);
        if (s > 8388607) s = 8388607;
        r = s[23:0];
        return r;
    endfunction

    function automatic logic [23:0] ref6(input logic [23:0] a, input logic [23:0] b);
        logic [23:0] r;
        logic [5:0]  x, y;
        int ix, iy, mx, mn, s;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            x = a[6*k +: 6];
            y = b[6*k +: 6];
            if (x == 6'h20) begin
                r[6*k +: 6] = y;
            end else if (y == 6'h20) begin
                r[6*k +: 6] = x;
            end else begin
                ix = $signed(x);
                iy = $signed(y);
                mx = (ix > iy) ? ix : iy;
                mn = (ix > iy) ? iy : ix;
                s  = mx + ((mx - mn <= 1) ? 1 : 0);
                if (s > 31) s = 31;
                r[6*k +: 6] = s[5:0];
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] ref_model(input logic [23:0] a, input logic [23:0] b,
                                              input logic [1:0] m);
        return (m == 2'b01) ? ref6(a, b) : ref24(a, b);
    endfunction

    // Drive one cycle of inputs, pass one rising edge, sample 1 time unit later.
    task automatic step(input logic r, input logic en, input logic [23:0] a,
                        input logic [23:0] b, input logic [1:0] m);
        rst       = r;
        enable    = en;
        operand_a = a;
        operand_b = b;
        pe_mode   = m;
        @(posedge clk);
        #1;
        if (r) begin
            p_v        = 1'b0;
            exp_valid  = 1'b0;
            exp_result = '0;
        end else begin
            exp_valid = p_v;
            if (p_v) exp_result = p_r;
            p_v = en;
            p_r = ref_model(a, b, m);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, $urandom(), $urandom(), 2'($urandom_range(0, 3)));
    endtask

    function automatic logic [23:0] pick_b(input logic [23:0] a, input int sel);
        case (sel)
            0:       return 24'($urandom());
            1:       return a + 24'($urandom_range(0, 2047)) - 24'd1024;
            2:       return 24'h800000;
            default: return a;
        endcase
    endfunction

    task automatic test_reset();
        step(1'b1, 1'b0, '0, '0, 2'b00);
        step(1'b1, 1'b1, 24'h123456, 24'h000001, 2'b00);
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid: got %b want 0", valid_out);
        end
        n_checks++;
        if (result !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_result: got %h want 000000", result);
        end
    endtask

    task automatic test_basic_latency();
        idle();
        step(1'b0, 1'b1, 24'h000800, 24'h000700, 2'b00);
        // Result registered at the next edge; a downstream register sees it at the second edge.
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_early: valid_out got %b want 0", valid_out);
        end
        idle();
        n_checks++;
        if (valid_out !== 1'b1 || result !== 24'h000900) begin
            n_errors++;
            $display("FAIL basic_add: got v=%b r=%h want v=1 r=000900", valid_out, result);
        end
        idle();
        n_checks++;
        if (valid_out !== 1'b0 || result !== 24'h000900) begin
            n_errors++;
            $display("FAIL hold_after: got v=%b r=%h want v=0 r=000900", valid_out, result);
        end
    endtask

    task automatic test_neg_inf();
        logic [23:0] va [4] = '{24'h800000, 24'h123456, 24'h800000, 24'h000000};
        logic [23:0] vb [4] = '{24'h123456, 24'h800000, 24'h800000, 24'h123456};
        logic [23:0] vw [4] = '{24'h123456, 24'h123456, 24'h800000, 24'h123456};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, va[i], vb[i], 2'b00);
            idle();
            n_checks++;
            if (valid_out !== 1'b1 || result !== vw[i]) begin
                n_errors++;
                $display("FAIL neg_inf_%0d: got v=%b r=%h want v=1 r=%h", i, valid_out, result,
                         vw[i]);
            end
        end
    endtask

    task automatic test_signed_sat();
        step(1'b0, 1'b1, 24'hFFFFFF, 24'h000001, 2'b00);
        idle();
        n_checks++;
        if (valid_out !== 1'b1 || result !== 24'h000003) begin
            n_errors++;
            $display("FAIL signed_diff2: got v=%b r=%h want v=1 r=000003", valid_out, result);
        end
        lut[0] = 10'h3FF;
        // Reserved mode 10 must behave as scalar mode.
        step(1'b0, 1'b1, 24'h7FFF00, 24'h7FFF00, 2'b10);
        idle();
        n_checks++;
        if (valid_out !== 1'b1 || result !== 24'h7FFFFF) begin
            n_errors++;
            $display("FAIL sat24: got v=%b r=%h want v=1 r=7fffff", valid_out, result);
        end
        lut[0] = 10'h000;
    endtask

    task automatic test_packed();
        logic [23:0] va [2] = '{24'h1450E0, 24'h7DF7DF};
        logic [23:0] vb [2] = '{24'h144407, 24'h7DF7DF};
        logic [23:0] vw [2] = '{24'h186407, 24'h7DF7DF};
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, va[i], vb[i], 2'b01);
            idle();
            n_checks++;
            if (valid_out !== 1'b1 || result !== vw[i]) begin
                n_errors++;
                $display("FAIL packed_%0d: got v=%b r=%h want v=1 r=%h", i, valid_out, result,
                         vw[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] a;
        int n_valid = 0;
        for (int i = 0; i < 7; i++) begin
            a = 24'($urandom());
            if (i < 5) step(1'b0, 1'b1, a, pick_b(a, i % 4), 2'(i % 2));
            else idle();
            if (valid_out === 1'b1) n_valid++;
            n_checks++;
            if (valid_out !== exp_valid || result !== exp_result) begin
                n_errors++;
                $display("FAIL b2b_%0d: got v=%b r=%h want v=%b r=%h", i, valid_out, result,
                         exp_valid, exp_result);
            end
        end
        n_checks++;
        if (n_valid != 5) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d valid results want 5", n_valid);
        end
    endtask

    task automatic test_gap();
        logic want_v [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        idle();
        for (int i = 0; i < 5; i++) begin
            if (i == 0 || i == 2) step(1'b0, 1'b1, 24'h000100, 24'h000100, 2'b00);
            else idle();
            n_checks++;
            if (valid_out !== want_v[i]) begin
                n_errors++;
                $display("FAIL gap_%0d: valid_out got %b want %b", i, valid_out, want_v[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        step(1'b0, 1'b1, 24'h000800, 24'h000700, 2'b00);
        step(1'b0, 1'b1, 24'h1450E0, 24'h144407, 2'b01);
        step(1'b1, 1'b1, 24'h000010, 24'h000020, 2'b00);
        n_checks++;
        if (valid_out !== 1'b0 || result !== 24'h0) begin
            n_errors++;
            $display("FAIL midflight_reset: got v=%b r=%h want v=0 r=000000", valid_out, result);
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            n_checks++;
            if (valid_out !== 1'b0 || result !== 24'h0) begin
                n_errors++;
                $display("FAIL stale_%0d: got v=%b r=%h want v=0 r=000000", i, valid_out, result);
            end
        end
        step(1'b0, 1'b1, 24'hFFFFFF, 24'h000001, 2'b00);
        idle();
        n_checks++;
        if (valid_out !== 1'b1 || result !== 24'h000003) begin
            n_errors++;
            $display("FAIL post_reset: got v=%b r=%h want v=1 r=000003", valid_out, result);
        end
    endtask

    task automatic test_random();
        logic [23:0] a;
        for (int i = 0; i < 1024; i++) lut[i] = 10'($urandom());
        for (int i = 0; i < 400; i++) begin
            a = 24'($urandom());
            if ($urandom_range(0, 7) == 0) a = 24'h800000;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), a,
                 pick_b(a, $urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            n_checks++;
            if (valid_out !== exp_valid || result !== exp_result) begin
                n_errors++;
                $display("FAIL random_%0d: got v=%b r=%h want v=%b r=%h", i, valid_out, result,
                         exp_valid, exp_result);
            end
        end
        for (int i = 0; i < 1024; i++) lut[i] = 10'(i);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        operand_a = '0;
        operand_b = '0;
        pe_mode   = 2'b00;
        for (int i = 0; i < 1024; i++) lut[i] = 10'(i);
        test_reset();
        test_basic_latency();
        test_neg_inf();
        test_signed_sat();
        test_packed();
        test_back_to_back();
        test_gap();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
